led_pwm_fader: RTL and testbench
================================

# led_pwm_fader

Brightness stage between the free-running pattern counter and the LED output buffers. It takes the 8-bit LED pattern (`ctr[25:18]`) and gates it with a PWM duty that ramps up, holds, ramps down and holds off, in an endless breathing cycle. Pattern and duty change only at PWM period boundaries, so the LEDs never glitch. The block runs entirely in the PLL output clock domain.

## Interface
Parameters:
- `NUM_LEDS`, default 8: width of the pattern and LED buses.
- `PWM_BITS`, default 8: PWM counter and duty width; `DMAX = 2^PWM_BITS-1`.
- `PRESCALE`, default 256: clocks per PWM count tick; must be ≥1.
- `STEP_PERIODS`, default 4: PWM periods per duty step while ramping; must be ≥1.
- `HOLD_PERIODS`, default 64: PWM periods spent in each hold state; must be ≥1.

Ports:
- `clk`, in, 1: the single clock, driven by the PLL output.
- `resetn`, in, 1: reset, synchronous and active-low.
- `pattern`, in, NUM_LEDS: raw LED pattern; asynchronous to PWM periods.
- `freeze`, in, 1: when high, the state machine and duty hold their values while the PWM keeps running.
- `leds`, out, NUM_LEDS: registered gated pattern, sent to the output IOBs.
- `duty`, out, PWM_BITS: current duty (debug).
- `state`, out, 2: current FSM state (debug).

## Operation
- Prescaler `pre` counts 0..PRESCALE-1. `tick` = (`pre` == PRESCALE-1).
- `pwm_cnt` increments on `tick` and wraps from DMAX to 0.
- `period_end` = `tick` && (`pwm_cnt` == DMAX).
- On `period_end`:
  - `pat_q` <= `pattern`.
  - The period counter `pcnt` advances, and the FSM is evaluated (skipped if `freeze` is high; `pcnt` also holds).
- FSM states (encoding 0..3):
  - `RISE`: every STEP_PERIODS period ends, `duty`+1. When `duty` reaches DMAX, go to `HOLD_HI` with `pcnt`=0.
  - `HOLD_HI`: after HOLD_PERIODS period ends, go to `FALL`.
  - `FALL`: every STEP_PERIODS period ends, `duty`-1. When `duty` reaches 0, go to `HOLD_LO`.
  - `HOLD_LO`: after HOLD_PERIODS period ends, go to `RISE`.
- `duty` saturates and never wraps. `pcnt` is cleared on every state change and on every ramp step.
- Output: `leds[i]` <= `pat_q[i]` & (`pwm_cnt` < `duty`), registered.
  - `duty` = 0 means fully off.
  - `duty` = DMAX means on for DMAX/2^PWM_BITS of each period (never 100%).
- `freeze` sampled high on a `period_end` suppresses that evaluation only. Deasserting it resumes from the held state and `pcnt`.

## Timing
- Reset (`resetn` low at a clock edge) sets: `pre`, `pwm_cnt`, `pcnt`, `duty`, `pat_q` and `leds` to 0, and `state` to `RISE`. This applies mid-operation too, with no drain.
- PWM period length = PRESCALE·2^PWM_BITS clocks.
- Pattern latency: `pattern` sampled at a `period_end` edge appears on `leds` one clock later. A mid-period `pattern` change is invisible until the next boundary.
- A `duty` change takes effect on the same schedule, at period start plus 1 clock.
- One full breathing cycle = (2·DMAX·STEP_PERIODS + 2·HOLD_PERIODS) periods.
- `duty` and `state` outputs are the registers themselves, with zero added latency.

## Structure
- Package `led_pwm_pkg`: FSM state encoding constants (`RISE`=0, `HOLD_HI`=1, `FALL`=2, `HOLD_LO`=3) and the default parameter values.
- Sub-module `pwm_timebase`: holds `pre` and `pwm_cnt`; outputs `pwm_cnt`, `tick` and `period_end`.
- Top level: FSM, `duty`, `pcnt`, `pat_q` and the output register.

## Test plan
All cases use PRESCALE=2, PWM_BITS=4, STEP_PERIODS=1, HOLD_PERIODS=2, giving a period of 32 clocks and a full cycle of 34 periods.
- Reset: `resetn` low for 5 clocks with `pattern`=FF → `leds`=00, `duty`=0, `state`=0 throughout. After release, `duty`=1 one clock after the first `period_end` (clock 32).
- Ramp: free run → `duty` goes 0..15 over 15 periods, then `state` = `HOLD_HI` for 2 periods, `FALL` down to 0, `HOLD_LO` for 2 periods, then back to `RISE` at period 34.
- Duty gating: `pattern`=A5 with `duty`=15 → `leds`=A5 for 30 clocks and 00 for 2 clocks of each period. With `duty`=0 → `leds`=00 for the whole period.
- Freeze: assert `freeze` in `FALL` at `duty`=7 for 10 periods → `duty` stays 7 and `leds` are on 14 of 32 clocks. After release, `duty`=6 at the next boundary.
- Pattern isolation: change `pattern` 0F→F0 at clock 10 of a period → `leds` keep the 0F mask until 1 clock after that period's `period_end`, then show F0.
- Reset mid-run: pulse `resetn` low during `HOLD_HI` → on the next clock `leds`=00, `duty`=0, `state`=`RISE`. The ramp restarts from 0.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED breathing fader: FSM encoding and default parameters.
package led_pwm_pkg;

  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } fader_state_e;

  localparam int unsigned DEF_NUM_LEDS     = 8;
  localparam int unsigned DEF_PWM_BITS     = 8;
  localparam int unsigned DEF_PRESCALE     = 256;
  localparam int unsigned DEF_STEP_PERIODS = 4;
  localparam int unsigned DEF_HOLD_PERIODS = 64;

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler plus wrapping PWM counter, with tick and period-boundary strobes.
module pwm_timebase #(
  parameter int unsigned PRESCALE = 256,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                resetn,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                tick,
  output logic                period_end
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    tick       = (pre_q == PRE_W'(PRESCALE - 1));
    period_end = tick && (pwm_cnt_q == '1);
    pre_d      = tick ? '0 : pre_q + PRE_W'(1);
    pwm_cnt_d  = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pre_q     <= '0;
      pwm_cnt_q <= '0;
    end else begin
      pre_q     <= pre_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign pwm_cnt = pwm_cnt_q;

endmodule

// File: rtl/led_pwm_fader.sv
// LED breathing fader: ramps a PWM duty up/hold/down/hold and gates the LED pattern with it,
// updating pattern and duty only at PWM period boundaries.
module led_pwm_fader
  import led_pwm_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = DEF_NUM_LEDS,
  parameter int unsigned PWM_BITS     = DEF_PWM_BITS,
  parameter int unsigned PRESCALE     = DEF_PRESCALE,
  parameter int unsigned STEP_PERIODS = DEF_STEP_PERIODS,
  parameter int unsigned HOLD_PERIODS = DEF_HOLD_PERIODS
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_LEDS-1:0] pattern,
  input  logic                freeze,
  output logic [NUM_LEDS-1:0] leds,
  output logic [PWM_BITS-1:0] duty,
  output logic [1:0]          state
);

  localparam int unsigned PCNT_MAX = (STEP_PERIODS > HOLD_PERIODS) ? STEP_PERIODS : HOLD_PERIODS;
  localparam int unsigned PCNT_W   = $clog2(PCNT_MAX + 1);
  localparam logic [PWM_BITS-1:0] DMAX = '1;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic                period_end;

  fader_state_e        state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d, pcnt_inc;
  logic [NUM_LEDS-1:0] pat_q, pat_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;

  pwm_timebase #(
    .PRESCALE (PRESCALE),
    .PWM_BITS (PWM_BITS)
  ) u_timebase (
    .clk        (clk),
    .resetn     (resetn),
    .pwm_cnt    (pwm_cnt),
    .tick       (tick),
    .period_end (period_end)
  );

  // Breathing FSM, evaluated once per PWM period unless frozen.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    pcnt_d   = pcnt_q;
    pat_d    = pat_q;
    pcnt_inc = pcnt_q + PCNT_W'(1);
    leds_d   = pat_q & {NUM_LEDS{pwm_cnt < duty_q}};
    if (period_end) begin
      pat_d = pattern;
      if (!freeze) begin
        pcnt_d = pcnt_inc;
        unique case (state_q)
          RISE: begin
            if (pcnt_inc == PCNT_W'(STEP_PERIODS)) begin
              pcnt_d = '0;
              if (duty_q != DMAX) duty_d = duty_q + PWM_BITS'(1);
              if (duty_d == DMAX) state_d = HOLD_HI;
            end
          end
          HOLD_HI: begin
            if (pcnt_inc == PCNT_W'(HOLD_PERIODS)) begin
              pcnt_d  = '0;
              state_d = FALL;
            end
          end
          FALL: begin
            if (pcnt_inc == PCNT_W'(STEP_PERIODS)) begin
              pcnt_d = '0;
              if (duty_q != '0) duty_d = duty_q - PWM_BITS'(1);
              if (duty_d == '0) state_d = HOLD_LO;
            end
          end
          HOLD_LO: begin
            if (pcnt_inc == PCNT_W'(HOLD_PERIODS)) begin
              pcnt_d  = '0;
              state_d = RISE;
            end
          end
          default: state_d = RISE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= RISE;
      duty_q  <= '0;
      pcnt_q  <= '0;
      pat_q   <= '0;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      pcnt_q  <= pcnt_d;
      pat_q   <= pat_d;
      leds_q  <= leds_d;
    end
  end

  // A period boundary is always a prescaler tick.
  period_end_on_tick: assert property (@(posedge clk) disable iff (!resetn) period_end |-> tick);

  assign leds  = leds_q;
  assign duty  = duty_q;
  assign state = 2'(state_q);

endmodule

// File: tb/tb_led_pwm_fader.sv
// Randomized self-checking bench for led_pwm_fader against a period-level breathing model.
module tb_led_pwm_fader;

  localparam int unsigned NL = 8, PB = 4, PS = 2, SP = 1, HP = 2;
  localparam int DMAX   = (1 << PB) - 1;
  localparam int PERIOD = PS * (1 << PB);
  localparam int CYC    = 2 * DMAX * SP + 2 * HP;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          freeze = 1'b0;
  logic [NL-1:0] pattern = 8'hFF;
  logic [NL-1:0] leds;
  logic [PB-1:0] duty;
  logic [1:0]    state;

  int tests = 0;
  int fails = 0;

  led_pwm_fader #(
    .NUM_LEDS     (NL),
    .PWM_BITS     (PB),
    .PRESCALE     (PS),
    .STEP_PERIODS (SP),
    .HOLD_PERIODS (HP)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .pattern (pattern),
    .freeze  (freeze),
    .leds    (leds),
    .duty    (duty),
    .state   (state)
  );

  initial forever #5 clk = ~clk;

  // Duty/state after kk evaluated period ends, from the breathing-cycle shape.
  function automatic int m_duty(input int kk);
    int p;
    p = kk % CYC;
    if (p < DMAX * SP) return p / SP;
    if (p < DMAX * SP + HP) return DMAX;
    if (p < 2 * DMAX * SP + HP) return DMAX - (p - DMAX * SP - HP) / SP;
    return 0;
  endfunction

  function automatic int m_state(input int kk);
    int p;
    p = kk % CYC;
    if (p < DMAX * SP) return 0;
    if (p < DMAX * SP + HP) return 1;
    if (p < 2 * DMAX * SP + HP) return 2;
    return 3;
  endfunction

  // n: clocks since reset release; k: unfrozen period ends seen.
  int            n = 0;
  int            k = 0;
  logic [NL-1:0] pat_m = '0;
  logic [NL-1:0] leds_m = '0;
  bit            started = 1'b0;

  always @(posedge clk) begin
    started = 1'b1;
    if (!resetn) begin
      n = 0; k = 0; pat_m = '0; leds_m = '0;
    end else begin
      leds_m = (((n / PS) % (DMAX + 1)) < m_duty(k)) ? pat_m : '0;
      if (n % PERIOD == PERIOD - 1) begin
        pat_m = pattern;
        if (!freeze) k++;
      end
      n++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input int exp);
    tests++;
    if (act !== 32'(exp)) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("leds", 32'(leds), int'(leds_m));
      check("duty", 32'(duty), m_duty(k));
      check("state", 32'(state), m_state(k));
    end
  end

  task automatic wait_n(input int target);
    int b;
    b = 0;
    while (n != target && b < 5000) begin
      @(negedge clk);
      b++;
    end
    if (n != target) check("wait_timeout", 32'(n), target);
  endtask

  initial begin
    int cnt;
    logic [NL-1:0] bad;
    bit seen;

    // Reset held with all-on pattern.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_leds", 32'(leds), 0);
      check("rst_duty", 32'(duty), 0);
      check("rst_state", 32'(state), 0);
    end
    resetn = 1'b1;
    pattern = 8'hA5;

    wait_n(31);
    check("first_duty_pre", 32'(duty), 0);
    wait_n(32);
    check("first_duty", 32'(duty), 1);

    // Full-duty period gating.
    wait_n(480);
    check("hold_hi_duty", 32'(duty), 15);
    check("hold_hi_state", 32'(state), 1);
    cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (leds == 8'hA5) cnt++;
    end
    check("gate_duty15_on", 32'(cnt), 30);

    wait_n(1087);
    check("hold_lo_state", 32'(state), 3);
    wait_n(1088);
    check("cycle_wrap_state", 32'(state), 0);
    check("cycle_wrap_duty", 32'(duty), 0);
    cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (leds != 8'h00) cnt++;
    end
    check("gate_duty0_on", 32'(cnt), 0);

    // Freeze in FALL at duty 7 over ten period ends.
    wait_n(1888);
    check("fall7_duty", 32'(duty), 7);
    check("fall7_state", 32'(state), 2);
    freeze = 1'b1;
    cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (leds == 8'hA5) cnt++;
    end
    check("freeze_on_clocks", 32'(cnt), 14);
    wait_n(2208);
    check("freeze_held_duty", 32'(duty), 7);
    freeze = 1'b0;
    wait_n(2240);
    check("unfreeze_duty", 32'(duty), 6);

    // Pattern change mid-period stays hidden until the next boundary.
    wait_n(2250);
    pattern = 8'h0F;
    wait_n(2272);
    bad = '0;
    seen = 1'b0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (i == 9) pattern = 8'hF0;
      bad |= leds & 8'hF0;
      if (leds == 8'h0F) seen = 1'b1;
    end
    check("iso_old_mask", 32'(bad), 0);
    check("iso_old_seen", 32'(seen), 1);
    @(negedge clk);
    check("iso_new_mask", 32'(leds), 8'hF0);

    // Random pattern and freeze activity.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(15) == 0) pattern = 8'($urandom);
      if ($urandom_range(63) == 0) freeze = ~freeze;
    end
    freeze = 1'b0;

    // Reset pulse during HOLD_HI.
    begin
      int b;
      b = 0;
      while (m_state(k) != 1 && b < 3000) begin
        @(negedge clk);
        b++;
      end
      if (m_state(k) != 1) check("wait_hold_hi", 32'(m_state(k)), 1);
    end
    repeat (7) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_leds", 32'(leds), 0);
    check("midrst_duty", 32'(duty), 0);
    check("midrst_state", 32'(state), 0);
    resetn = 1'b1;
    wait_n(32);
    check("midrst_ramp", 32'(duty), 1);
    repeat (600) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
